// File: rtl/pp_ingress_arbiter.sv
// pp_ingress_arbiter
// Packet-granular round-robin arbiter that shares the parser's single
// AXI-Stream ingress between NUM_PORTS sources. The granted port is passed
// through combinationally. Packets longer than MAX_PKT_LENGTH beats are cut
// with a forced tlast, and their remainder is silently drained.
module pp_ingress_arbiter #(
   parameter int NUM_PORTS      = 4,
   parameter int TDATA_WIDTH    = 8,
   parameter int TUSER_WIDTH    = 128,
   parameter int MAX_PKT_LENGTH = 65535,
   parameter int CNT_W          = 16,
   parameter int ID_W           = 2
) (
   input  logic                             aclk,
   input  logic                             aresetn,
   input  logic [NUM_PORTS-1:0]             s_tvalid,
   output logic [NUM_PORTS-1:0]             s_tready,
   input  logic [NUM_PORTS*TDATA_WIDTH-1:0] s_tdata,
   input  logic [NUM_PORTS*TUSER_WIDTH-1:0] s_tuser,
   input  logic [NUM_PORTS-1:0]             s_tlast,
   output logic                             m_tvalid,
   input  logic                             m_tready,
   output logic [TDATA_WIDTH-1:0]           m_tdata,
   output logic [TUSER_WIDTH-1:0]           m_tuser,
   output logic                             m_tlast,
   output logic [ID_W-1:0]                  m_tid,
   output logic                             trunc_err,
   output logic [15:0]                      trunc_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ID_W-1:0]     gnt;
   logic [ID_W-1:0]     gnt_nxt;
   logic [ID_W-1:0]     last_gnt;
   logic [ID_W-1:0]     last_gnt_nxt;
   logic [CNT_W-1:0]    beat_cnt;
   logic [CNT_W-1:0]    beat_cnt_nxt;
   logic                trunc_set;

   logic                sel_valid;
   logic                sel_last;
   logic [TDATA_WIDTH-1:0] sel_data;
   logic [TUSER_WIDTH-1:0] sel_user;
   logic                pick_found;
   logic [ID_W-1:0]     pick_idx;
   logic [ID_W-1:0]     cand;
   logic                at_max;
   logic                pass_hs;

   // Saturating increment for the truncation counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Select the granted port's stream signals using constant slices only.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = {TDATA_WIDTH{1'b0}};
      sel_user  = {TUSER_WIDTH{1'b0}};
      for (int i = 0; i < NUM_PORTS; i++) begin
         sel_valid = (gnt == ID_W'(i)) ? s_tvalid[i] : sel_valid;
         sel_last  = (gnt == ID_W'(i)) ? s_tlast[i]  : sel_last;
         sel_data  = (gnt == ID_W'(i)) ? s_tdata[i*TDATA_WIDTH +: TDATA_WIDTH] : sel_data;
         sel_user  = (gnt == ID_W'(i)) ? s_tuser[i*TUSER_WIDTH +: TUSER_WIDTH] : sel_user;
      end
   end

   // Round-robin pick: scan downward so the port nearest after last_gnt wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = {ID_W{1'b0}};
      cand       = {ID_W{1'b0}};
      for (int i = NUM_PORTS; i >= 1; i--) begin
         cand       = ID_W'((int'(last_gnt) + i) % NUM_PORTS);
         pick_found = pick_found | s_tvalid[cand];
         pick_idx   = s_tvalid[cand] ? cand : pick_idx;
      end
   end

   assign at_max  = (beat_cnt == CNT_W'(MAX_PKT_LENGTH - 1));
   assign pass_hs = (state == PASS) && sel_valid && m_tready;
   assign m_tid   = gnt;

   // Next-state logic: grant, beat count and truncation detection.
   always_comb begin
      state_nxt    = state;
      gnt_nxt      = gnt;
      last_gnt_nxt = last_gnt;
      beat_cnt_nxt = beat_cnt;
      trunc_set    = 1'b0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt    = PASS;
               gnt_nxt      = pick_idx;
               beat_cnt_nxt = {CNT_W{1'b0}};
            end else begin
               state_nxt    = IDLE;
            end
         end
         PASS: begin
            if (pass_hs) begin
               beat_cnt_nxt = beat_cnt + CNT_W'(1);
               if (sel_last) begin
                  // Genuine end of packet wins over truncation on the same beat.
                  state_nxt    = IDLE;
                  last_gnt_nxt = gnt;
               end else if (at_max) begin
                  state_nxt = DRAIN;
                  trunc_set = 1'b1;
               end else begin
                  state_nxt = PASS;
               end
            end else begin
               state_nxt = PASS;
            end
         end
         DRAIN: begin
            if (sel_valid && sel_last) begin
               state_nxt    = IDLE;
               last_gnt_nxt = gnt;
            end else begin
               state_nxt = DRAIN;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output decode: pass-through in PASS, sink-only in DRAIN, quiet in IDLE.
   always_comb begin
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      m_tdata  = {TDATA_WIDTH{1'b0}};
      m_tuser  = {TUSER_WIDTH{1'b0}};
      s_tready = {NUM_PORTS{1'b0}};
      case (state)
         PASS: begin
            m_tvalid = sel_valid;
            m_tlast  = sel_last | at_max;
            m_tdata  = sel_data;
            m_tuser  = sel_user;
            for (int i = 0; i < NUM_PORTS; i++) begin
               s_tready[i] = (gnt == ID_W'(i)) ? m_tready : 1'b0;
            end
         end
         DRAIN: begin
            for (int i = 0; i < NUM_PORTS; i++) begin
               s_tready[i] = (gnt == ID_W'(i));
            end
         end
         IDLE: begin
            m_tvalid = 1'b0;
         end
         default: begin
            m_tvalid = 1'b0;
         end
      endcase
   end

   // State and counter registers; last_gnt resets so port 0 is served first.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= IDLE;
         gnt       <= {ID_W{1'b0}};
         last_gnt  <= ID_W'(NUM_PORTS - 1);
         beat_cnt  <= {CNT_W{1'b0}};
         trunc_cnt <= 16'd0;
         trunc_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         gnt       <= gnt_nxt;
         last_gnt  <= last_gnt_nxt;
         beat_cnt  <= beat_cnt_nxt;
         trunc_err <= trunc_set;
         if (trunc_set) begin
            trunc_cnt <= sat_inc16(trunc_cnt);
         end
      end
   end

endmodule

// File: tb/tb_pp_ingress_arbiter.sv
// Self-checking bench for pp_ingress_arbiter. Sources are packet queues; the
// expected output stream is derived from round-robin order over pending
// packets and per-packet truncation to MAXL beats.
module tb_pp_ingress_arbiter;

   localparam int NP   = 4;
   localparam int DW   = 8;
   localparam int UW   = 128;
   localparam int MAXL = 8;
   localparam int IDW  = 2;

   logic              aclk = 1'b0;
   logic              aresetn = 1'b0;
   logic [NP-1:0]     s_tvalid = '0;
   logic [NP-1:0]     s_tready;
   logic [NP*DW-1:0]  s_tdata = '0;
   logic [NP*UW-1:0]  s_tuser = '0;
   logic [NP-1:0]     s_tlast = '0;
   logic              m_tvalid;
   logic              m_tready = 1'b0;
   logic [DW-1:0]     m_tdata;
   logic [UW-1:0]     m_tuser;
   logic              m_tlast;
   logic [IDW-1:0]    m_tid;
   logic              trunc_err;
   logic [15:0]       trunc_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   pp_ingress_arbiter #(
      .NUM_PORTS(NP), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW),
      .MAX_PKT_LENGTH(MAXL), .CNT_W(16), .ID_W(IDW)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .s_tuser(s_tuser), .s_tlast(s_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
      .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tid(m_tid),
      .trunc_err(trunc_err), .trunc_cnt(trunc_cnt)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [7:0] d;
      int         tid;
      bit         last;
   } beat_t;

   logic [7:0] src_data [NP][$];
   bit         src_last [NP][$];
   int         pend_len [NP][$];
   beat_t      exp_q[$];
   int         model_last;
   int         model_trunc_total;
   int         exp_trunc_run;
   int         out_tid[$];
   int         out_cyc[$];
   int         first_valid_cyc;
   int         trunc_pulses;

   function automatic logic [UW-1:0] tuser_of(input logic [7:0] d, input int p);
      return {{15{d}}, 8'(p)};
   endfunction

   task automatic clear_queues();
      for (int p = 0; p < NP; p++) begin
         src_data[p].delete();
         src_last[p].delete();
         pend_len[p].delete();
      end
      exp_q.delete();
   endtask

   task automatic do_reset();
      s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tuser = '0; m_tready = 1'b0;
      @(negedge aclk);
      aresetn = 1'b0;
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      model_last        = NP - 1;
      model_trunc_total = 0;
      clear_queues();
   endtask

   task automatic add_pkt(input int p, input int len, input int base, input bit rnd);
      logic [7:0] d;
      pend_len[p].push_back(len);
      for (int k = 0; k < len; k++) begin
         d = rnd ? 8'($urandom) : 8'(base + k);
         src_data[p].push_back(d);
         src_last[p].push_back(k == len - 1);
      end
   endtask

   // Reference: every port with packets pending requests continuously, so
   // service order is plain round robin over non-empty packet lists.
   task automatic build_expected();
      int pos [NP];
      int pick;
      int len;
      int n;
      int c;
      for (int p = 0; p < NP; p++) pos[p] = 0;
      exp_trunc_run = 0;
      exp_q.delete();
      forever begin
         pick = -1;
         for (int i = 1; i <= NP; i++) begin
            c = (model_last + i) % NP;
            if (pick < 0 && pend_len[c].size() > 0) pick = c;
         end
         if (pick < 0) break;
         len = pend_len[pick].pop_front();
         n   = (len > MAXL) ? MAXL : len;
         for (int k = 0; k < n; k++) begin
            exp_q.push_back('{src_data[pick][pos[pick] + k], pick, (k == n - 1)});
         end
         pos[pick] += len;
         if (len > MAXL) exp_trunc_run++;
         model_last = pick;
      end
      model_trunc_total += exp_trunc_run;
   endtask

   // Drive all queued packets, check each output beat and the ready pattern.
   // mode 0: m_tready=1, mode 1: 1,0,0 repeating, other: random.
   task automatic run_traffic(input int mode, input int budget);
      int cyc;
      bit done;
      bit empty;
      beat_t e;
      cyc = 0; done = 1'b0;
      out_tid.delete(); out_cyc.delete();
      first_valid_cyc = -1; trunc_pulses = 0;
      build_expected();
      while (!done && cyc < budget) begin
         @(negedge aclk);
         for (int p = 0; p < NP; p++) begin
            if (src_data[p].size() > 0) begin
               s_tvalid[p] = 1'b1;
               s_tdata[p*DW +: DW] = src_data[p][0];
               s_tuser[p*UW +: UW] = tuser_of(src_data[p][0], p);
               s_tlast[p] = src_last[p][0];
            end else begin
               s_tvalid[p] = 1'b0;
               s_tlast[p]  = 1'b0;
            end
         end
         case (mode)
            0:       m_tready = 1'b1;
            1:       m_tready = (cyc % 3 == 0);
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (trunc_err) trunc_pulses++;
         n_checks++;
         if ($countones(s_tready) > 1) begin
            n_fail++;
            $display("FAIL ready_onehot cyc=%0d s_tready=%b expected at most one bit", cyc, s_tready);
         end
         if (m_tvalid) begin
            n_checks++;
            if (s_tready !== (NP'(m_tready) << m_tid)) begin
               n_fail++;
               $display("FAIL ready_follow cyc=%0d s_tready=%b expected %b", cyc, s_tready,
                        NP'(m_tready) << m_tid);
            end
         end
         if (m_tvalid && m_tready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL extra_beat cyc=%0d got data=%h tid=%0d expected no beat", cyc, m_tdata, m_tid);
            end else begin
               e = exp_q.pop_front();
               if ({m_tdata, m_tid, m_tlast, m_tuser} !== {e.d, IDW'(e.tid), e.last, tuser_of(e.d, e.tid)}) begin
                  n_fail++;
                  $display("FAIL beat cyc=%0d got data=%h tid=%0d last=%b user_ok=%b expected data=%h tid=%0d last=%b",
                           cyc, m_tdata, m_tid, m_tlast, (m_tuser === tuser_of(e.d, e.tid)), e.d, e.tid, e.last);
               end
               out_tid.push_back(int'(m_tid));
               out_cyc.push_back(cyc);
            end
         end
         for (int p = 0; p < NP; p++) begin
            if (s_tvalid[p] && s_tready[p]) begin
               void'(src_data[p].pop_front());
               void'(src_last[p].pop_front());
            end
         end
         cyc++;
         empty = 1'b1;
         for (int p = 0; p < NP; p++) if (src_data[p].size() > 0) empty = 1'b0;
         done = empty && (exp_q.size() == 0);
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL timeout got %0d beats outstanding expected 0 within %0d cycles", exp_q.size(), budget);
      end
      @(negedge aclk);
      s_tvalid = '0; s_tlast = '0;
      #1;
      if (trunc_err) trunc_pulses++;
      n_checks++;
      if (m_tvalid !== 1'b0 || s_tready !== '0) begin
         n_fail++;
         $display("FAIL back_to_idle got m_tvalid=%b s_tready=%b expected 0 and 0000", m_tvalid, s_tready);
      end
      n_checks++;
      if (trunc_pulses !== exp_trunc_run) begin
         n_fail++;
         $display("FAIL trunc_err_pulses got %0d expected %0d", trunc_pulses, exp_trunc_run);
      end
      n_checks++;
      if (trunc_cnt !== 16'(model_trunc_total)) begin
         n_fail++;
         $display("FAIL trunc_cnt got %0d expected %0d", trunc_cnt, model_trunc_total);
      end
   endtask

   task automatic test_reset();
      @(negedge aclk);
      aresetn  = 1'b0;
      s_tvalid = '1; s_tlast = '1; s_tdata = '1; s_tuser = '1; m_tready = 1'b1;
      #1;
      n_checks++;
      if ({m_tvalid, m_tlast, trunc_err} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ctrl got valid/last/err=%b expected 000", {m_tvalid, m_tlast, trunc_err});
      end
      n_checks++;
      if (s_tready !== '0) begin
         n_fail++;
         $display("FAIL reset_ready got %b expected 0000", s_tready);
      end
      n_checks++;
      if (m_tid !== '0 || m_tdata !== '0 || m_tuser !== '0) begin
         n_fail++;
         $display("FAIL reset_data got tid=%0d data=%h expected 0 and 00", m_tid, m_tdata);
      end
      n_checks++;
      if (trunc_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_trunc_cnt got %0d expected 0", trunc_cnt);
      end
      do_reset();
   endtask

   task automatic test_single_port();
      do_reset();
      add_pkt(0, 4, 8'hA1, 1'b0);
      run_traffic(0, 200);
      n_checks++;
      if (first_valid_cyc !== 1) begin
         n_fail++;
         $display("FAIL first_valid_latency got cycle %0d expected 1", first_valid_cyc);
      end
      n_checks++;
      if (out_tid.size() !== 4) begin
         n_fail++;
         $display("FAIL single_beats got %0d expected 4", out_tid.size());
      end
   endtask

   task automatic test_round_robin();
      int exp_seq [8];
      int gaps;
      exp_seq = '{0, 0, 1, 1, 2, 2, 0, 0};
      do_reset();
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < 3; p++) add_pkt(p, 2, 16 * p + 4 * r, 1'b0);
      run_traffic(0, 300);
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (i >= out_tid.size() || out_tid[i] !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL rr_seq idx=%0d got %0d expected %0d", i,
                     (i < out_tid.size()) ? out_tid[i] : -1, exp_seq[i]);
         end
      end
      gaps = (out_cyc.size() == 12) ? (out_cyc[11] - out_cyc[0] + 1 - 12) : -1;
      n_checks++;
      if (gaps !== 5) begin
         n_fail++;
         $display("FAIL rr_bubbles got %0d expected 5", gaps);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      add_pkt(3, 6, 8'h30, 1'b0);
      run_traffic(1, 300);
      n_checks++;
      if (out_tid.size() !== 6) begin
         n_fail++;
         $display("FAIL bp_beats got %0d expected 6", out_tid.size());
      end
   endtask

   task automatic test_truncation();
      do_reset();
      add_pkt(1, 12, 0, 1'b0);
      run_traffic(0, 300);
      n_checks++;
      if (out_tid.size() !== MAXL) begin
         n_fail++;
         $display("FAIL trunc_beats got %0d expected %0d", out_tid.size(), MAXL);
      end
   endtask

   task automatic test_exact_max();
      do_reset();
      add_pkt(2, MAXL, 8'h80, 1'b0);
      run_traffic(0, 300);
      n_checks++;
      if (out_tid.size() !== MAXL) begin
         n_fail++;
         $display("FAIL exact_beats got %0d expected %0d", out_tid.size(), MAXL);
      end
   endtask

   task automatic test_reset_mid_packet();
      int k;
      do_reset();
      k = 0;
      for (int c = 0; c < 20 && k < 2; c++) begin
         @(negedge aclk);
         m_tready = 1'b1;
         s_tvalid = 4'b0100;
         s_tdata[2*DW +: DW] = 8'(8'h20 + k);
         s_tlast = '0;
         #1;
         if (m_tvalid && m_tready) k++;
      end
      @(negedge aclk);
      s_tdata[2*DW +: DW] = 8'h22;
      #1;
      n_checks++;
      if (k !== 2 || m_tvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pkt_setup got beats=%0d valid=%b expected 2 and 1", k, m_tvalid);
      end
      aresetn = 1'b0;
      #1;
      n_checks++;
      if (m_tvalid !== 1'b0 || s_tready !== '0) begin
         n_fail++;
         $display("FAIL mid_pkt_reset got valid=%b ready=%b expected 0 and 0000", m_tvalid, s_tready);
      end
      s_tvalid = '0;
      @(negedge aclk);
      aresetn = 1'b1;
      model_last = NP - 1;
      model_trunc_total = 0;
      clear_queues();
      add_pkt(2, 3, 8'h50, 1'b0);
      add_pkt(0, 2, 8'h60, 1'b0);
      run_traffic(0, 200);
      n_checks++;
      if (out_tid.size() == 0 || out_tid[0] !== 0) begin
         n_fail++;
         $display("FAIL post_reset_first_grant got %0d expected 0",
                  (out_tid.size() > 0) ? out_tid[0] : -1);
      end
   endtask

   task automatic test_random();
      int n;
      do_reset();
      for (int r = 0; r < 8; r++) begin
         for (int p = 0; p < NP; p++) begin
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) add_pkt(p, $urandom_range(1, 12), 0, 1'b1);
         end
         run_traffic(2, 3000);
      end
   endtask

   initial begin
      test_reset();
      test_single_port();
      test_round_robin();
      test_backpressure();
      test_truncation();
      test_exact_max();
      test_reset_mid_packet();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pp_ingress_arbiter.md
Name: pp_ingress_arbiter

Overview:
- Shares the single packet-parser ingress between NUM_PORTS AXI-Stream sources.
- Grants are packet-granular and round-robin; a grant is held until the granted port's tlast beat is accepted.
- Enforces MAX_PKT_LENGTH: an over-length packet is truncated with a forced tlast, and its remainder is drained and discarded.
- Sits directly in front of the parser's AXI-Stream slave port.

Parameters:
- NUM_PORTS, 4, number of source ports (2..8).
- TDATA_WIDTH, 8, tdata width in bits per port.
- TUSER_WIDTH, 128, tuser sideband width per port.
- MAX_PKT_LENGTH, 65535, maximum beats forwarded per packet.
- CNT_W, 16, beat counter width; must satisfy 2^CNT_W > MAX_PKT_LENGTH.
- ID_W, 2, width of port index; equals clog2(NUM_PORTS), minimum 1.

Ports:
- aclk  in  1  single clock; all logic on rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- s_tvalid  in  NUM_PORTS  per-port valid.
- s_tready  out  NUM_PORTS  per-port ready.
- s_tdata  in  NUM_PORTS*TDATA_WIDTH  flattened data; port i at [i*TDATA_WIDTH +: TDATA_WIDTH].
- s_tuser  in  NUM_PORTS*TUSER_WIDTH  flattened sideband, same packing.
- s_tlast  in  NUM_PORTS  per-port end of packet.
- m_tvalid  out  1  to parser.
- m_tready  in  1  from parser.
- m_tdata  out  TDATA_WIDTH  muxed data.
- m_tuser  out  TUSER_WIDTH  muxed sideband.
- m_tlast  out  1  end of packet; also forced on truncation.
- m_tid  out  ID_W  index of the source port.
- trunc_err  out  1  one-cycle pulse when a packet is truncated.
- trunc_cnt  out  16  truncated-packet count; saturates at 0xFFFF.

Behaviour:
- States:
  - IDLE: no grant held.
  - PASS: granted port forwarded to the parser.
  - DRAIN: discard remainder of a truncated packet.
- Registers: state, gnt (ID_W), last_gnt (ID_W), beat_cnt (CNT_W), trunc_cnt.
- Reset (async assert):
  - state=IDLE, gnt=0, last_gnt=NUM_PORTS-1 (port 0 wins first), beat_cnt=0, trunc_cnt=0.
  - All s_tready=0, m_tvalid=0, m_tlast=0, trunc_err=0.
  - m_tid=0, m_tdata=0, m_tuser=0.
- IDLE:
  - All s_tready=0, m_tvalid=0.
  - If any s_tvalid is set, gnt <= first requesting port searching last_gnt+1, last_gnt+2, ... modulo NUM_PORTS.
  - Then state <= PASS, beat_cnt <= 0.
  - Arbitration costs exactly one bubble cycle per packet.
- PASS (combinational pass-through, zero latency):
  - m_tvalid = s_tvalid[gnt]; m_tdata/m_tuser from port gnt.
  - m_tlast = s_tlast[gnt] OR (beat_cnt == MAX_PKT_LENGTH-1).
  - s_tready[gnt] = m_tready; all other s_tready = 0.
  - m_tid = gnt.
  - On handshake (m_tvalid && m_tready), beat_cnt increments.
- PASS exits, evaluated only on a handshake beat:
  - s_tlast[gnt]=1: state <= IDLE, last_gnt <= gnt. Takes priority over truncation when both hold on the same beat; no error in that case.
  - Else if beat_cnt == MAX_PKT_LENGTH-1: forced m_tlast was sent. Then trunc_err=1 for the next cycle only, trunc_cnt++ (saturating), state <= DRAIN.
- DRAIN:
  - s_tready[gnt]=1, others 0; m_tvalid=0.
  - Beats are accepted and discarded.
  - On s_tvalid[gnt] && s_tlast[gnt]: state <= IDLE, last_gnt <= gnt.
- Stability:
  - While m_tvalid && !m_tready, outputs track the source, which is AXI-compliant and must hold its values.
  - The arbiter never changes gnt mid-packet.
- A non-granted port may assert s_tvalid indefinitely; it is served within NUM_PORTS packets (starvation-free).
- A single-beat packet (tlast on the first beat) is legal; beat_cnt returns to 0 for the next grant.
- Reset mid-packet: immediate return to reset values. The partially sent packet is abandoned; the parser handles it via its own reset.

Test Plan:
1. Reset; port 0 only sends 4 beats 0xA1..0xA4 with tlast on the 4th.
   -> m_tvalid rises one cycle after s_tvalid[0].
   -> 4 beats out with m_tid=0 and m_tlast on 0xA4.
   -> Then IDLE; no trunc_err.
2. Ports 0, 1 and 2 continuously offer 2-beat packets.
   -> m_tid sequence 0,0,1,1,2,2,0,0.
   -> Exactly one m_tvalid=0 bubble between packets.
3. Port 3 sends a 6-beat packet while m_tready toggles 1,0,0,1,...
   -> s_tready[3] equals m_tready every cycle; other s_tready stay 0.
   -> Exactly 6 beats transferred, in order, with no duplicates.
4. MAX_PKT_LENGTH=8; port 1 sends a 12-beat packet, data 0..11.
   -> Beats 0..7 out, m_tlast on beat 7.
   -> trunc_err pulses once; trunc_cnt=1.
   -> Beats 8..11 accepted with m_tvalid=0; returns to IDLE after beat 11.
5. MAX_PKT_LENGTH=8; 8-beat packet with s_tlast on beat 8.
   -> Forwarded intact; trunc_err=0; no DRAIN.
6. aresetn deasserted during beat 3 of a port 2 packet.
   -> Same cycle: m_tvalid=0 and all s_tready=0.
   -> After release, with ports 0 and 2 both requesting, port 0 is granted first.
